// File: rtl/vga_scanout_if.sv
// Scan-out bundle: framebuffer read port plus video/status outputs.
// The scan engine is the master and drives everything except the SRAM read data.
interface vga_scanout_if #(
  parameter int D_WIDTH = 3,
  parameter int A_WIDTH = 15
);
  logic [A_WIDTH-1:0] fb_read_addr;
  logic [D_WIDTH-1:0] fb_read_data;
  logic [D_WIDTH-1:0] pixel;
  logic               hsync;
  logic               vsync;
  logic               active;
  logic               vblank;
  logic               frame_start;

  modport master (
    output fb_read_addr, pixel, hsync, vsync, active, vblank, frame_start,
    input  fb_read_data
  );

  modport slave (
    input  fb_read_addr, pixel, hsync, vsync, active, vblank, frame_start,
    output fb_read_data
  );
endinterface

// File: rtl/vga_scanout.sv
// Raster scan-out: VGA timing counters, SCALE x SCALE framebuffer addressing and a
// two-stage output pipeline aligning the registered SRAM data with the sync signals.
module vga_scanout #(
  parameter int D_WIDTH        = 3,
  parameter int A_WIDTH        = 15,
  parameter int SCALE          = 4,
  parameter int CLKS_PER_PIXEL = 2,
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33
) (
  input  logic          clk,
  input  logic          rst,
  vga_scanout_if.master bus
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int DW        = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam int SW        = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int ROW_WORDS = H_ACTIVE / SCALE;

  localparam logic [DW-1:0]      DIV_LAST = DW'(CLKS_PER_PIXEL - 1);
  localparam logic [SW-1:0]      SUB_LAST = SW'(SCALE - 1);
  localparam logic [HW-1:0]      H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]      H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]      HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]      HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]      V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]      V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]      VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]      VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [A_WIDTH-1:0] ROW_STEP = A_WIDTH'(ROW_WORDS);

  logic [DW-1:0]      r_div;
  logic [HW-1:0]      r_h;
  logic [VW-1:0]      r_v;
  logic [SW-1:0]      r_col_sub;
  logic [SW-1:0]      r_row_sub;
  logic [A_WIDTH-1:0] r_col;
  logic [A_WIDTH-1:0] r_row_base;
  logic               r_s1_active, r_s1_hs, r_s1_vs;
  logic [D_WIDTH-1:0] r_pixel;
  logic               r_hsync, r_vsync, r_active;
  logic               r_vblank, r_frame_start;

  logic w_tick, w_in_region, w_hs_raw, w_vs_raw, w_frame_origin;
  logic [A_WIDTH-1:0] w_addr;

  assign w_tick         = (r_div == DIV_LAST);
  assign w_in_region    = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_raw       = !((r_h >= HS_START) && (r_h < HS_END));
  assign w_vs_raw       = !((r_v >= VS_START) && (r_v < VS_END));
  assign w_frame_origin = (r_h == '0) && (r_v == '0) && (r_div == '0);
  // Row base and column run past the active area; the region mask hides that.
  assign w_addr         = w_in_region ? (r_row_base + r_col) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_col_sub     <= '0;
      r_row_sub     <= '0;
      r_col         <= '0;
      r_row_base    <= '0;
      r_s1_active   <= 1'b0;
      r_s1_hs       <= 1'b1;
      r_s1_vs       <= 1'b1;
      r_pixel       <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_active      <= 1'b0;
      r_vblank      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so each stage samples last cycle's counters.
      if (w_tick) begin
        r_div <= '0;
        if (r_h == H_LAST) begin
          r_h       <= '0;
          r_col     <= '0;
          r_col_sub <= '0;
          if (r_v == V_LAST) begin
            r_v        <= '0;
            r_row_base <= '0;
            r_row_sub  <= '0;
          end else begin
            r_v <= r_v + 1'b1;
            if (r_row_sub == SUB_LAST) begin
              r_row_sub  <= '0;
              r_row_base <= r_row_base + ROW_STEP;
            end else begin
              r_row_sub <= r_row_sub + 1'b1;
            end
          end
        end else begin
          r_h <= r_h + 1'b1;
          if (r_col_sub == SUB_LAST) begin
            r_col_sub <= '0;
            r_col     <= r_col + 1'b1;
          end else begin
            r_col_sub <= r_col_sub + 1'b1;
          end
        end
      end else begin
        r_div <= r_div + 1'b1;
      end

      // Stage 1 lines up with the SRAM's registered read of w_addr.
      r_s1_active   <= w_in_region;
      r_s1_hs       <= w_hs_raw;
      r_s1_vs       <= w_vs_raw;
      r_pixel       <= r_s1_active ? bus.fb_read_data : '0;
      r_hsync       <= r_s1_hs;
      r_vsync       <= r_s1_vs;
      r_active      <= r_s1_active;
      r_vblank      <= (r_v >= V_ACT);
      r_frame_start <= w_frame_origin;
    end
  end

  assign bus.fb_read_addr = w_addr;
  assign bus.pixel        = r_pixel;
  assign bus.hsync        = r_hsync;
  assign bus.vsync        = r_vsync;
  assign bus.active       = r_active;
  assign bus.vblank       = r_vblank;
  assign bus.frame_start  = r_frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a shrunken-timing instance checked cycle-by-cycle against an
// arithmetic raster model, plus a default-timing instance probed at known addresses.
module tb_vga_scanout;

  localparam int SC = 4, CPP = 2;
  localparam int HA = 32, HF = 4, HS = 8, HB = 4;
  localparam int VA = 16, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT * CPP;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s, rst_b, geom_en;

  vga_scanout_if #(.D_WIDTH(3), .A_WIDTH(AW)) if_s ();
  vga_scanout_if #(.D_WIDTH(3), .A_WIDTH(15)) if_b ();

  vga_scanout #(
    .D_WIDTH(3), .A_WIDTH(AW), .SCALE(SC), .CLKS_PER_PIXEL(CPP),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) u_small (.clk(clk), .rst(rst_s), .bus(if_s));

  vga_scanout #(.D_WIDTH(3), .A_WIDTH(15)) u_big (.clk(clk), .rst(rst_b), .bus(if_b));

  // Framebuffer SRAMs: registered read, one clk of latency.
  logic [2:0] mem_s [256];
  always @(posedge clk) if_s.fb_read_data <= mem_s[if_s.fb_read_addr];
  always @(posedge clk) if_b.fb_read_data <= if_b.fb_read_addr[2:0];

  int n_pass = 0, n_checks = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct { int v; int h; int d; } pos_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [2:0]    pixel;
    logic          hsync, vsync, active, vblank, frame_start;
  } obs_t;

  // Raster position after k clocks since reset, by plain division.
  function automatic pos_t pos_of(int k);
    pos_t r;
    int   p;
    p   = k / CPP;
    r.d = k % CPP;
    r.h = p % HT;
    r.v = (p / HT) % VT;
    return r;
  endfunction

  function automatic bit in_reg(pos_t r);
    return (r.h < HA) && (r.v < VA);
  endfunction

  function automatic int addr_of(pos_t r);
    return (r.v / SC) * (HA / SC) + r.h / SC;
  endfunction

  function automatic obs_t model_s(int k);
    obs_t o;
    pos_t p0, p1, p2;
    bit   a;
    o = '0;
    o.hsync = 1'b1;
    o.vsync = 1'b1;
    p0 = pos_of(k);
    o.addr = in_reg(p0) ? AW'(addr_of(p0)) : '0;
    if (k >= 1) begin
      p1 = pos_of(k - 1);
      o.vblank      = (p1.v >= VA);
      o.frame_start = (p1.h == 0) && (p1.v == 0) && (p1.d == 0);
    end
    if (k >= 2) begin
      p2 = pos_of(k - 2);
      a = in_reg(p2);
      o.active = a;
      o.hsync  = !((p2.h >= HA + HF) && (p2.h < HA + HF + HS));
      o.vsync  = !((p2.v >= VA + VF) && (p2.v < VA + VF + VS));
      o.pixel  = a ? mem_s[addr_of(p2)] : 3'd0;
    end
    return o;
  endfunction

  // Probe points on the default 640x480 instance: kind 0 addr, 1 pixel, 2 hsync,
  // 3 active, 4 frame_start; k is clocks since reset release.
  localparam int NPT = 23;
  localparam int PT_KIND [NPT] = '{0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1, 2,2,2,2, 3,3,4,4};
  localparam int PT_K    [NPT] = '{0,7,8,1272,1279,1280,6400,11207,12800,
                                   9,10,17,18,1281,1282, 1313,1314,1505,1506, 1,2,1,2};
  localparam int PT_EXP  [NPT] = '{0,0,1,159,159,0,160,160,320,
                                   0,1,1,2,7,0, 1,0,0,1, 0,1,1,0};

  // Scoreboard: each clock edge pushes the expected observation; the monitor pops it.
  int   ks = 0, kb = 0;
  bit   run_s = 1'b0, run_b = 1'b0;
  obs_t exp_q [$];

  always @(posedge clk) begin
    if (rst_s) begin ks = 0; run_s = 1'b1; end
    else if (run_s) ks++;
    if (rst_b) begin kb = 0; run_b = 1'b1; end
    else if (run_b) kb++;
    if (run_s) exp_q.push_back(model_s(ks));
  end

  int   cyc = 0, last_fs = -1, hs_fall = -1, vs_fall = -1;
  logic prev_fs = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1, prev_vb = 1'b0;
  obs_t e, a;
  pos_t pv;

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.addr        = if_s.fb_read_addr;
      a.pixel       = if_s.pixel;
      a.hsync       = if_s.hsync;
      a.vsync       = if_s.vsync;
      a.active      = if_s.active;
      a.vblank      = if_s.vblank;
      a.frame_start = if_s.frame_start;
      check("scan{addr,pix,hs,vs,act,vb,fs}", 64'(a), 64'(e));
    end

    if (geom_en) begin
      if (if_s.frame_start && !prev_fs) begin
        if (last_fs >= 0) check("frame_period", 64'(cyc - last_fs), 64'(FRAME));
        last_fs = cyc;
      end
      if (!if_s.frame_start && prev_fs && last_fs >= 0)
        check("frame_start_width", 64'(cyc - last_fs), 64'd1);
      if (!if_s.hsync && prev_hs) hs_fall = cyc;
      if (if_s.hsync && !prev_hs && hs_fall >= 0)
        check("hsync_low_clks", 64'(cyc - hs_fall), 64'(HS * CPP));
      if (!if_s.vsync && prev_vs) vs_fall = cyc;
      if (if_s.vsync && !prev_vs && vs_fall >= 0)
        check("vsync_low_clks", 64'(cyc - vs_fall), 64'(VS * HT * CPP));
      if (if_s.vblank && !prev_vb) begin
        pv = pos_of(ks - 1);
        check("vblank_rise", 64'((pv.v * HT + pv.h) * CPP + pv.d), 64'(VA * HT * CPP));
      end
    end else begin
      last_fs = -1;
      hs_fall = -1;
      vs_fall = -1;
    end
    prev_fs = if_s.frame_start;
    prev_hs = if_s.hsync;
    prev_vs = if_s.vsync;
    prev_vb = if_s.vblank;

    if (run_b) begin
      for (int i = 0; i < NPT; i++) begin
        if (kb == PT_K[i]) begin
          case (PT_KIND[i])
            0: check($sformatf("big_addr_k%0d", kb), 64'(if_b.fb_read_addr), 64'(PT_EXP[i]));
            1: check($sformatf("big_pixel_k%0d", kb), 64'(if_b.pixel), 64'(PT_EXP[i]));
            2: check($sformatf("big_hsync_k%0d", kb), 64'(if_b.hsync), 64'(PT_EXP[i]));
            3: check($sformatf("big_active_k%0d", kb), 64'(if_b.active), 64'(PT_EXP[i]));
            default: check($sformatf("big_fs_k%0d", kb), 64'(if_b.frame_start), 64'(PT_EXP[i]));
          endcase
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem_s[i] = 3'($urandom);
    rst_s = 1'b1;
    rst_b = 1'b1;
    geom_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hsync", 64'(if_s.hsync), 64'd1);
    check("reset_pixel_active", 64'({if_s.pixel, if_s.active}), 64'd0);
    rst_s = 1'b0;
    rst_b = 1'b0;
    geom_en = 1'b1;

    // Three uninterrupted frames for period and sync geometry.
    n = 0;
    while (ks < 3 * FRAME + 20 && n < 4 * FRAME) begin @(negedge clk); n++; end
    check("wait_three_frames", 64'(ks >= 3 * FRAME + 20), 64'd1);
    geom_en = 1'b0;

    // Mid-frame reset at line 6, h=15, then scan must restart cleanly.
    n = 0;
    while ((ks % FRAME) != (6 * HT + 15) * CPP && n < FRAME + 10) begin @(negedge clk); n++; end
    check("wait_midframe_point", 64'((ks % FRAME) == (6 * HT + 15) * CPP), 64'd1);
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    repeat (50) @(negedge clk);

    // Randomly placed reset pulses of random length.
    repeat (3) begin
      repeat ($urandom_range(1, FRAME)) @(negedge clk);
      rst_s = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_s = 1'b0;
    end
    repeat (FRAME / 2) @(negedge clk);

    n = 0;
    while (kb < 12900 && n < 20000) begin @(negedge clk); n++; end
    check("wait_big_probes", 64'(kb >= 12900), 64'd1);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
